// File: rtl/mod_counter_bcd_pkg.sv
// Shared types and elaboration helpers for the BCD up/down counter.
package mod_counter_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int unsigned ADD3_THRESH = 5;
  localparam int unsigned ADD3_VAL    = 3;

  // Bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r++;
    end
    return r;
  endfunction

  // Smallest digit count whose decimal range covers max_val.
  function automatic int unsigned min_digits(input int unsigned max_val);
    int unsigned d;
    int unsigned p;
    d = 1;
    p = 10;
    for (int unsigned i = 0; i < 10; i++) begin
      if (p <= max_val) begin
        d++;
        p = p * 10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/mod_counter_bcd_if.sv
// Control and result bundle between the counter and its user.
interface mod_counter_bcd_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      d;
  logic [WIDTH-1:0]      q;
  logic                  tc;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;

  modport master (output en, up, load, d, input q, tc, bcd, bcd_valid);
  modport slave  (input en, up, load, d, output q, tc, bcd, bcd_valid);
endinterface

// File: rtl/mod_counter_bcd_seq_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter; restarts whenever value moves.
module seq_bin2bcd
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    value,
  output logic [4*DIGITS-1:0] bcd,
  output logic                valid
);
  localparam int unsigned CW = clog2(WIDTH + 1);
  localparam int unsigned AW = 4 * DIGITS;

  state_t            state;
  logic [WIDTH-1:0]  snap;
  logic [WIDTH-1:0]  sh;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_adj;
  logic [AW-1:0]     acc_shift;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     bcd_r;

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'(ADD3_THRESH))
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'(ADD3_VAL);
    end
    acc_shift = {acc_adj[AW-2:0], sh[WIDTH-1]};
  end

  // snap stays equal to the converted value so a change is detected mid-shift;
  // sh is the shadow that actually shifts out into acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      snap  <= '0;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd_r <= '0;
    end else if (value != snap) begin
      snap  <= value;
      sh    <= value;
      acc   <= '0;
      cnt   <= CW'(WIDTH);
      state <= SHIFT;
    end else if (state == SHIFT) begin
      acc <= acc_shift;
      sh  <= sh << 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bcd_r <= acc_shift;
        state <= IDLE;
      end
    end
  end

  assign bcd   = bcd_r;
  assign valid = (state == IDLE) && (value == snap);
endmodule

// File: rtl/mod_counter_bcd.sv
// Loadable up/down counter with terminal value, wrap/saturate and BCD readout.
module mod_counter_bcd
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned DIGITS   = 3
) (
  input logic              clk,
  input logic              rst_n,
  mod_counter_bcd_if.slave bus
);
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "mod_counter_bcd: WIDTH must be 2..16");
  end
  if (DIGITS < min_digits(MAX)) begin : g_bad_digits
    $fatal(1, "mod_counter_bcd: DIGITS too small for MAX");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_r;
  logic             tc_nxt;

  always_comb begin
    q_nxt  = q_r;
    tc_nxt = 1'b0;
    if (bus.load) begin
      q_nxt = (bus.d > MAX_Q) ? MAX_Q : bus.d;
    end else if (bus.en) begin
      if (bus.up) begin
        if (q_r == MAX_Q) begin
          tc_nxt = 1'b1;
          q_nxt  = SATURATE ? MAX_Q : '0;
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end else begin
        if (q_r == '0) begin
          tc_nxt = 1'b1;
          q_nxt  = SATURATE ? '0 : MAX_Q;
        end else begin
          q_nxt = q_r - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r  <= '0;
      tc_r <= 1'b0;
    end else begin
      q_r  <= q_nxt;
      tc_r <= tc_nxt;
    end
  end

  assign bus.q  = q_r;
  assign bus.tc = tc_r;

  seq_bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .value (q_r),
    .bcd   (bus.bcd),
    .valid (bus.bcd_valid)
  );
endmodule

// File: tb/tb_mod_counter_bcd.sv
// Bench: three counter configurations driven in lockstep against a latency-based model.
module tb_mod_counter_bcd;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = W + 1;
  localparam int unsigned N   = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] d;

  logic [7:0]  dq    [N];
  logic        dtc   [N];
  logic [11:0] dbcd  [N];
  logic        dval  [N];

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  // 0: MAX=255 wrap, 1: MAX=199 saturate, 2: MAX=199 wrap
  int unsigned MAXV [N] = '{255, 199, 199};
  bit          SATV [N] = '{1'b0, 1'b1, 1'b0};

  for (genvar g = 0; g < N; g++) begin : g_dut
    mod_counter_bcd_if #(.WIDTH(W), .DIGITS(3)) bus ();
    assign bus.en   = en;
    assign bus.up   = up;
    assign bus.load = load;
    assign bus.d    = d;
    assign dq[g]    = bus.q;
    assign dtc[g]   = bus.tc;
    assign dbcd[g]  = bus.bcd;
    assign dval[g]  = bus.bcd_valid;
    mod_counter_bcd #(
      .WIDTH    (W),
      .MAX      ((g == 0) ? 255 : 199),
      .SATURATE ((g == 1) ? 1'b1 : 1'b0),
      .DIGITS   (3)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: counter rules plus "bcd follows q once q has been stable for LAT edges".
  int unsigned m_q      [N];
  bit          m_tc     [N];
  logic [11:0] m_bcd    [N];
  int unsigned m_stable [N];

  function automatic logic [11:0] to_bcd(input int unsigned v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned nq;
    bit          ntc;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_q[i]      <= 0;
        m_tc[i]     <= 1'b0;
        m_bcd[i]    <= '0;
        m_stable[i] <= LAT;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        nq  = m_q[i];
        ntc = 1'b0;
        if (load) begin
          nq = (int'(d) > MAXV[i]) ? MAXV[i] : int'(d);
        end else if (en) begin
          if (up) begin
            if (m_q[i] == MAXV[i]) begin
              ntc = 1'b1;
              nq  = SATV[i] ? MAXV[i] : 0;
            end else nq = m_q[i] + 1;
          end else begin
            if (m_q[i] == 0) begin
              ntc = 1'b1;
              nq  = SATV[i] ? 0 : MAXV[i];
            end else nq = m_q[i] - 1;
          end
        end
        if (m_stable[i] == LAT - 1) m_bcd[i] <= to_bcd(m_q[i]);
        m_stable[i] <= (nq != m_q[i]) ? 0 : ((m_stable[i] >= LAT) ? LAT : m_stable[i] + 1);
        m_q[i]  <= nq;
        m_tc[i] <= ntc;
      end
    end
  end

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s[cfg%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, ".q"},         i, 32'(dq[i]),   32'(m_q[i]));
      chk({tag, ".tc"},        i, 32'(dtc[i]),  32'(m_tc[i]));
      chk({tag, ".bcd"},       i, 32'(dbcd[i]), 32'(m_bcd[i]));
      chk({tag, ".bcd_valid"}, i, 32'(dval[i]), 32'(m_stable[i] >= LAT));
    end
  endtask

  task automatic cyc(input string tag, input bit l, input int unsigned dv, input bit e, input bit u);
    load = l;
    d    = 8'(dv);
    en   = e;
    up   = u;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cyc(tag, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    up    = 1'b0;
    load  = 1'b0;
    d     = '0;
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    idle("reset_idle", 12);

    // Up-count through the top: wrap on cfg0/cfg2, saturate on cfg1 (253 clamps to 199)
    cyc("load253", 1'b1, 253, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc("up_wrap", 1'b0, 0, 1'b1, 1'b1);
    idle("up_wrap_settle", 10);

    // Out-of-range load clamps; held en at the limit keeps tc high
    cyc("load230", 1'b1, 230, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc("sat_hold", 1'b0, 0, 1'b1, 1'b1);
    idle("sat_settle", 10);

    // Down through zero
    cyc("load1", 1'b1, 1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc("down_wrap", 1'b0, 0, 1'b1, 1'b0);
    idle("down_settle", 10);

    // Reload of the current value must not restart conversion
    cyc("reload_same", 1'b1, 199, 1'b0, 1'b0);
    idle("reload_settle", 10);
    cyc("reload_same2", 1'b1, 199, 1'b0, 1'b0);
    idle("reload_settle2", 3);

    // Change mid-conversion aborts the first result
    cyc("load45", 1'b1, 45, 1'b0, 1'b0);
    idle("mid_conv", 2);
    cyc("load178", 1'b1, 178, 1'b0, 1'b0);
    idle("abort_settle", 10);

    // Async reset between edges while shifting
    cyc("load100", 1'b1, 100, 1'b0, 1'b0);
    idle("pre_rst", 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc("post_rst_up", 1'b0, 0, 1'b1, 1'b1);
    idle("post_rst_settle", 10);

    // Randomized traffic with occasional quiet stretches so conversions complete
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) idle("rand_quiet", $urandom_range(5, 12));
      else cyc("rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 255),
               ($urandom_range(0, 2) != 0), 1'($urandom));
    end
    idle("final", 12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
